// File: rtl/sequential_divider.sv
`default_nettype none
// ============================================================================
// Module   : sequential_divider
// Purpose  : Multi-cycle restoring shift-subtract integer divider. It produces
//            one quotient bit per clock, so a divide takes WIDTH+1 clocks from
//            the start edge to the done pulse. A zero divisor completes in
//            one clock.
// Config   : SIGNED_DIV_EN - when defined, operands are two's complement.
//            The magnitudes are divided, and the sign is applied on the final
//            iteration edge. The quotient truncates toward zero and the
//            remainder takes the sign of the dividend.
//            When undefined, operands are unsigned and overflow_out is 0.
// Ports    : clock, reset            - rising-edge clock, sync active-high reset
//            start_in                - request, honoured in IDLE or DONE only
//            dividend_in, divisor_in - operands, sampled with start_in
//            busy_out                - high while iterating
//            done_out                - one-cycle result-valid pulse
//            quotient_out, remainder_out - results, held until next start
//            div_by_zero_out, overflow_out - status flags, valid with results
// Revision : 1.0 - initial release
// ============================================================================
module sequential_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_in,
  input  logic [WIDTH-1:0] dividend_in,
  input  logic [WIDTH-1:0] divisor_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             div_by_zero_out,
  output logic             overflow_out
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // partial remainder
  logic [WIDTH-1:0] shf_q, shf_d;     // dividend bits out, quotient bits in
  logic [WIDTH-1:0] dsr_q, dsr_d;     // divisor (magnitude)
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
`ifdef SIGNED_DIV_EN
  logic             qneg_q, qneg_d;   // quotient must be negated
  logic             rneg_q, rneg_d;   // remainder must be negated
  logic             ovfp_q, ovfp_d;   // most-negative / -1 seen at accept
  logic             ovf_q, ovf_d;
`endif

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] acc_nx, shf_nx, q_fin, r_fin, dvd_mag, dsr_mag;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    shf_d   = shf_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SIGNED_DIV_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    ovfp_d  = ovfp_q;
    ovf_d   = ovf_q;
`endif

    // One restoring step. The partial remainder always stays below the
    // divisor, so the shifted trial value fits in WIDTH+1 bits, and the
    // restored value fits back into WIDTH bits.
    trial = {acc_q, shf_q[WIDTH-1]};
    if (trial >= {1'b0, dsr_q}) begin
      acc_nx = trial[WIDTH-1:0] - dsr_q;
      shf_nx = {shf_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx = trial[WIDTH-1:0];
      shf_nx = {shf_q[WIDTH-2:0], 1'b0};
    end

`ifdef SIGNED_DIV_EN
    dvd_mag = dividend_in[WIDTH-1] ? (~dividend_in + WIDTH'(1)) : dividend_in;
    dsr_mag = divisor_in[WIDTH-1]  ? (~divisor_in  + WIDTH'(1)) : divisor_in;
    q_fin   = qneg_q ? (~shf_nx + WIDTH'(1)) : shf_nx;
    r_fin   = rneg_q ? (~acc_nx + WIDTH'(1)) : acc_nx;
`else
    dvd_mag = dividend_in;
    dsr_mag = divisor_in;
    q_fin   = shf_nx;
    r_fin   = acc_nx;
`endif

    case (state_q)
      S_BUSY: begin
        acc_d = acc_nx;
        shf_d = shf_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          quot_d  = q_fin;
          rem_d   = r_fin;
`ifdef SIGNED_DIV_EN
          ovf_d   = ovfp_q;
`endif
        end
      end
      default: begin  // S_IDLE and S_DONE both accept a new request
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
        if (start_in) begin
`ifdef SIGNED_DIV_EN
          ovf_d = 1'b0;
`endif
          if (divisor_in == '0) begin
            state_d = S_DONE;
            quot_d  = '1;
            rem_d   = dividend_in;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_BUSY;
            acc_d   = '0;
            shf_d   = dvd_mag;
            dsr_d   = dsr_mag;
            cnt_d   = '0;
            quot_d  = '0;
            rem_d   = '0;
            dbz_d   = 1'b0;
`ifdef SIGNED_DIV_EN
            qneg_d  = dividend_in[WIDTH-1] ^ divisor_in[WIDTH-1];
            rneg_d  = dividend_in[WIDTH-1];
            ovfp_d  = (dividend_in == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (divisor_in == '1);
`endif
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      shf_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SIGNED_DIV_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      ovfp_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shf_q   <= shf_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef SIGNED_DIV_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      ovfp_q  <= ovfp_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy_out        = (state_q == S_BUSY);
  assign done_out        = (state_q == S_DONE);
  assign quotient_out    = quot_q;
  assign remainder_out   = rem_q;
  assign div_by_zero_out = dbz_q;
`ifdef SIGNED_DIV_EN
  assign overflow_out    = ovf_q;
`else
  assign overflow_out    = 1'b0;
`endif

endmodule
`default_nettype wire
